prog_modn_ctr: RTL and testbench
================================

# prog_modn_ctr

Runtime-programmable modulo-N counter: the parametrised successor to the fixed mod-N counter. It adds run-time modulus, up/down direction, enable, parallel load, wrap or saturate mode, a terminal-count output for cascading, and a sticky error flag. It sits in timing/sequencing paths (clock dividers, frame/slot counters, BCD-style cascades) where the modulus is set by software or a controlling FSM.

## Interface
- WIDTH, 4, count width in bits
- N_DEFAULT, 10, modulus after reset; legal range 2..2^WIDTH (elaboration error otherwise)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- en  in  1  count enable
- up  in  1  direction: 1 = increment, 0 = decrement
- sat  in  1  mode: 0 = wrap at boundary, 1 = saturate (hold) at boundary
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value to load
- mod_wr  in  1  modulus write strobe
- mod_val  in  WIDTH+1  new modulus; legal range 2..2^WIDTH
- err_clr  in  1  clears err
- count  out  WIDTH  current count, always in 0..mod_q-1
- mod_q  out  WIDTH+1  modulus in effect
- tc  out  1  terminal count, combinational: en & !load & ((up & count==mod_q-1) | (!up & count==0))
- wrap  out  1  registered one-cycle pulse: the counter wrapped on the previous edge
- err  out  1  sticky error flag

## Operation
- Reset (rst==0 at an edge): count=0, mod_q=N_DEFAULT, wrap=0, err=0. Reset overrides every other input.
- Modulus write: on mod_wr with mod_val in 2..2^WIDTH, mod_q<=mod_val. If mod_val is illegal (0, 1, or >2^WIDTH), mod_q is unchanged and err<=1.
- Effective modulus M for the current cycle = the value mod_q will hold after this edge (a legal mod_wr in this cycle applies).
- Priority per edge: load > modulus-range fix-up > count.
- Load: count<=load_val if load_val<M. Otherwise count<=M-1 and err<=1. No wrap pulse. en is ignored when load is high.
- Range fix-up (no load): if a legal mod_wr makes count>=M, count<=0 and no increment happens this cycle.
- Count (en=1, no load, no fix-up):
  - Up: count==M-1 wraps to 0 with wrap<=1 when sat=0, and holds at M-1 when sat=1. Otherwise count+1.
  - Down: count==0 goes to M-1 with wrap<=1 when sat=0, and holds at 0 when sat=1. Otherwise count-1.
- en=0: count holds; wrap<=0.
- tc asserts at the boundary regardless of sat, so cascaded stages can use it as their en.
- err: set as above. err_clr clears it. Setting wins over err_clr in the same cycle.
- All arithmetic uses WIDTH+1 bits internally, so M=2^WIDTH counts through the full range without overflow.

## Timing
- count, mod_q, wrap, err: registered, valid one cycle after the causing edge.
- tc: combinational from count, mod_q, en, up, load. There is no register in the cascade path, so an N-stage chain advances in the same cycle.
- New modulus takes effect at the same edge it is written. The boundary check at that edge uses the new M.
- Direction or sat changes take effect at the next edge. There is no pipeline, so latency is 1 cycle from any input to count.

## Structure
- Shared package prog_modn_pkg: function is_legal_mod(mod_val, WIDTH), and localparam MAX_MOD = 2^WIDTH.
- One sub-module, prog_modn_limit: combinational; from count, M, and up, it produces at_max, at_min, last=M-1, and range_bad (count>=M). The top level holds the registers and the priority logic.

## Test plan
- Reset with N_DEFAULT=10, en=1, up=1 for 12 cycles -> count 0..9, 0, 1; wrap high the cycle after 9->0; tc high while count==9.
- mod_wr with mod_val=5 while count=7 -> next count=0, mod_q=5; then counting 0..4 wraps.
- up=0, sat=1, count=2, en for 4 cycles -> 1, 0, 0, 0; tc high at 0; wrap never set. Then sat=0 -> next count=M-1 with wrap pulse.
- load_val=12 with M=10 -> count=9, err=1; err_clr -> err=0; load_val=3 -> count=3, err stays 0.
- mod_wr with mod_val=1, then 17 (WIDTH=4) -> mod_q unchanged, err=1. mod_val=16 -> counts 0..15 and wraps.
- Two instances chained (stage1 en = stage0 tc), both M=10 -> 00..99 then 00; rst low mid-count -> both 0 at the next edge.

Source files
------------

// File: rtl/prog_modn_pkg.sv
// Shared constants and helpers for the programmable modulo-N counter.
package prog_modn_pkg;

    // Default count width and the largest modulus it supports.
    localparam int CTR_WIDTH_DEFAULT = 4;
    localparam int MAX_MOD           = 2 ** CTR_WIDTH_DEFAULT;

    // A modulus is legal when it lies in 2..2^width.
    function automatic logic is_legal_mod(input logic [31:0] mod_val, input int width);
        logic [32:0] max_v;
        max_v = 33'd1 << width;
        return (mod_val >= 32'd2) && ({1'b0, mod_val} <= max_v);
    endfunction

endpackage

// File: rtl/prog_modn_ctr_if.sv
// Control/status bundle of the programmable modulo-N counter.
// There is no valid/ready handshake: load, mod_wr and err_clr are single-cycle
// strobes sampled at every rising clk edge; en/up/sat are levels sampled the
// same way; count/mod_q/wrap/err are registered, tc is combinational.
interface prog_modn_ctr_if #(parameter int WIDTH = 4);
    import prog_modn_pkg::*;

    logic             en;
    logic             up;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             mod_wr;
    logic [WIDTH:0]   mod_val;
    logic             err_clr;
    logic [WIDTH-1:0] count;
    logic [WIDTH:0]   mod_q;
    logic             tc;
    logic             wrap;
    logic             err;

    // Controller side: drives the strobes, observes the counter.
    modport master (
        output en, up, sat, load, load_val, mod_wr, mod_val, err_clr,
        input  count, mod_q, tc, wrap, err
    );

    // Counter side.
    modport slave (
        input  en, up, sat, load, load_val, mod_wr, mod_val, err_clr,
        output count, mod_q, tc, wrap, err
    );

endinterface

// File: rtl/prog_modn_limit.sv
// Boundary decode of a count against a modulus M (all compares in WIDTH+1 bits
// so M = 2^WIDTH works).
module prog_modn_limit
    import prog_modn_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH:0]   i_mod,
    output logic             o_at_max,
    output logic             o_at_min,
    output logic [WIDTH-1:0] o_last,
    output logic             o_range_bad
);

    logic [WIDTH:0] w_count_x;
    logic [WIDTH:0] w_last_x;

    assign w_count_x   = {1'b0, i_count};
    assign w_last_x    = i_mod - 1'b1;
    assign o_at_max    = (w_count_x == w_last_x);
    assign o_at_min    = (i_count == '0);
    // M <= 2^WIDTH, so M-1 always fits in WIDTH bits.
    assign o_last      = w_last_x[WIDTH-1:0];
    assign o_range_bad = (w_count_x >= i_mod);

endmodule

// File: rtl/prog_modn_ctr.sv
// Runtime-programmable modulo-N up/down counter with load, wrap/saturate
// mode, cascade terminal count and a sticky error flag.
module prog_modn_ctr
    import prog_modn_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int N_DEFAULT = 10
) (
    input  logic            clk,
    input  logic            rst,
    prog_modn_ctr_if.slave  ctr
);

    // Reject an out-of-range reset modulus at elaboration.
    generate
        if (!is_legal_mod(32'(N_DEFAULT), WIDTH)) begin : g_bad_default
            $error("prog_modn_ctr: N_DEFAULT out of range 2..2^WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   r_mod_q;
    logic             r_wrap;
    logic             r_err;

    logic             w_mod_ok;
    logic [WIDTH:0]   w_m;
    logic             w_at_max;
    logic             w_at_min;
    logic [WIDTH-1:0] w_last;
    logic             w_range_bad;
    logic             w_tc_at_max;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;
    logic             w_load_err;
    logic             w_err_set;

    // Effective modulus: a legal write this cycle is already in force at this edge.
    assign w_mod_ok = is_legal_mod(32'(ctr.mod_val), WIDTH);
    assign w_m      = (ctr.mod_wr && w_mod_ok) ? ctr.mod_val : r_mod_q;

    prog_modn_limit #(.WIDTH(WIDTH)) u_limit (
        .i_count     (r_count),
        .i_mod       (w_m),
        .o_at_max    (w_at_max),
        .o_at_min    (w_at_min),
        .o_last      (w_last),
        .o_range_bad (w_range_bad)
    );

    // tc looks at the modulus currently held, not a pending write, so a cascade
    // sees a stable boundary for the whole cycle.
    assign w_tc_at_max = ({1'b0, r_count} == (r_mod_q - 1'b1));
    assign ctr.tc      = ctr.en & ~ctr.load &
                         ((ctr.up & w_tc_at_max) | (~ctr.up & (r_count == '0)));

    // Next count/wrap with priority load > range fix-up > count.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        w_load_err  = 1'b0;
        if (ctr.load) begin
            if ({1'b0, ctr.load_val} < w_m) begin
                w_count_nxt = ctr.load_val;
            end else begin
                w_count_nxt = w_last;
                w_load_err  = 1'b1;
            end
        end else if (w_range_bad) begin
            w_count_nxt = '0;
        end else if (ctr.en) begin
            if (ctr.up) begin
                if (w_at_max) begin
                    if (!ctr.sat) begin
                        w_count_nxt = '0;
                        w_wrap_nxt  = 1'b1;
                    end
                end else begin
                    w_count_nxt = r_count + 1'b1;
                end
            end else begin
                if (w_at_min) begin
                    if (!ctr.sat) begin
                        w_count_nxt = w_last;
                        w_wrap_nxt  = 1'b1;
                    end
                end else begin
                    w_count_nxt = r_count - 1'b1;
                end
            end
        end
    end

    assign w_err_set = w_load_err | (ctr.mod_wr & ~w_mod_ok);

    // State registers; a set of err beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
            r_mod_q <= (WIDTH+1)'(N_DEFAULT);
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_mod_q <= w_m;
            r_wrap  <= w_wrap_nxt;
            r_err   <= w_err_set | (r_err & ~ctr.err_clr);
        end
    end

    assign ctr.count = r_count;
    assign ctr.mod_q = r_mod_q;
    assign ctr.wrap  = r_wrap;
    assign ctr.err   = r_err;

endmodule

// File: tb/tb_prog_modn_ctr.sv
// Bench for prog_modn_ctr: vector table with scoreboard, plus a two-stage
// decimal cascade sequence.
module tb_prog_modn_ctr;

  localparam int W = 4;

  typedef struct {
    bit en, up, sat, ld;
    int lv;
    bit mw;
    int mv;
    bit clr, rst_n, tc;
    int c, m;
    bit w, e;
  } vec_t;

  vec_t vecs[$];
  logic [10:0] exp_q[$];
  int          idx_q[$];
  int          total = 0;
  int          bad   = 0;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_c = 1'b0;
  always #5 clk = ~clk;

  prog_modn_ctr_if #(.WIDTH(W)) bus ();
  prog_modn_ctr_if #(.WIDTH(W)) c0_if ();
  prog_modn_ctr_if #(.WIDTH(W)) c1_if ();

  prog_modn_ctr #(.WIDTH(W), .N_DEFAULT(10)) dut (.clk(clk), .rst(rst), .ctr(bus));
  prog_modn_ctr #(.WIDTH(W), .N_DEFAULT(10)) st0 (.clk(clk), .rst(rst_c), .ctr(c0_if));
  prog_modn_ctr #(.WIDTH(W), .N_DEFAULT(10)) st1 (.clk(clk), .rst(rst_c), .ctr(c1_if));

  assign c1_if.en = c0_if.tc;

  task automatic add(input bit en, up, sat, ld, input int lv, input bit mw, input int mv,
                     input bit clr, rst_n, tc, input int c, m, input bit w, e);
    vec_t v;
    v.en = en; v.up = up; v.sat = sat; v.ld = ld; v.lv = lv; v.mw = mw; v.mv = mv;
    v.clr = clr; v.rst_n = rst_n; v.tc = tc; v.c = c; v.m = m; v.w = w; v.e = e;
    vecs.push_back(v);
  endtask

  // driver: apply at negedge, check combinational tc, push post-edge expectation
  task automatic drive(input vec_t v, input int idx);
    @(negedge clk);
    rst          = v.rst_n;
    bus.en       = v.en;
    bus.up       = v.up;
    bus.sat      = v.sat;
    bus.load     = v.ld;
    bus.load_val = W'(v.lv);
    bus.mod_wr   = v.mw;
    bus.mod_val  = (W+1)'(v.mv);
    bus.err_clr  = v.clr;
    #1;
    total++;
    if (bus.tc !== v.tc) begin
      bad++;
      $display("FAIL tc vec %0d: got %0b want %0b", idx, bus.tc, v.tc);
    end
    exp_q.push_back({W'(v.c), (W+1)'(v.m), v.w, v.e});
    idx_q.push_back(idx);
  endtask

  // scoreboard: pop one expectation after each active edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [10:0] exp_v;
      logic [10:0] act_v;
      int          idx;
      exp_v = exp_q.pop_front();
      idx   = idx_q.pop_front();
      act_v = {bus.count, bus.mod_q, bus.wrap, bus.err};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL state vec %0d: count/mod_q/wrap/err got %0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b",
                 idx, act_v[10:7], act_v[6:2], act_v[1], act_v[0],
                 exp_v[10:7], exp_v[6:2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic chk_chain(input string name, input int want);
    int got;
    got = int'(c1_if.count) * 10 + int'(c0_if.count);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    bus.en = 0; bus.up = 1; bus.sat = 0; bus.load = 0; bus.load_val = '0;
    bus.mod_wr = 0; bus.mod_val = '0; bus.err_clr = 0;
    c0_if.en = 1; c0_if.up = 1; c0_if.sat = 0; c0_if.load = 0; c0_if.load_val = '0;
    c0_if.mod_wr = 0; c0_if.mod_val = '0; c0_if.err_clr = 0;
    c1_if.up = 1; c1_if.sat = 0; c1_if.load = 0; c1_if.load_val = '0;
    c1_if.mod_wr = 0; c1_if.mod_val = '0; c1_if.err_clr = 0;

    // --- vector table: en up sat ld lv mw mv clr rst_n | tc | count mod_q wrap err
    add(0,1,0,0,0, 0,0, 0,0, 0, 0,10,0,0);
    add(1,1,0,1,5, 1,1, 0,0, 0, 0,10,0,0);           // reset beats load/mod_wr
    for (int i = 0; i < 12; i++)
      add(1,1,0,0,0, 0,0, 0,1, (i % 10) == 9, (i + 1) % 10, 10, i == 9, 0);
    for (int i = 2; i < 7; i++)
      add(1,1,0,0,0, 0,0, 0,1, 0, i + 1, 10, 0, 0);
    add(1,1,0,0,0, 1,5, 0,1, 0, 0,5,0,0);            // fix-up: 7 >= 5
    for (int i = 0; i < 6; i++)
      add(1,1,0,0,0, 0,0, 0,1, (i % 5) == 4, (i + 1) % 5, 5, i == 4, 0);
    add(1,1,0,0,0, 0,0, 0,1, 0, 2,5,0,0);
    add(1,0,1,0,0, 0,0, 0,1, 0, 1,5,0,0);            // down, saturate
    add(1,0,1,0,0, 0,0, 0,1, 0, 0,5,0,0);
    add(1,0,1,0,0, 0,0, 0,1, 1, 0,5,0,0);
    add(1,0,1,0,0, 0,0, 0,1, 1, 0,5,0,0);
    add(1,0,0,0,0, 0,0, 0,1, 1, 4,5,1,0);            // down wrap to M-1
    add(0,0,0,0,0, 0,0, 0,1, 0, 4,5,0,0);
    add(0,1,0,0,0, 1,10, 0,1, 0, 4,10,0,0);
    add(1,1,0,1,12, 0,0, 0,1, 0, 9,10,0,1);          // load >= M clamps
    add(0,1,0,0,0, 0,0, 1,1, 0, 9,10,0,0);
    add(0,1,0,1,3, 0,0, 0,1, 0, 3,10,0,0);
    add(0,1,0,1,15, 0,0, 1,1, 0, 9,10,0,1);          // set beats clear
    add(0,1,0,0,0, 0,0, 1,1, 0, 9,10,0,0);
    add(0,1,0,0,0, 1,1, 0,1, 0, 9,10,0,1);           // illegal modulus 1
    add(0,1,0,0,0, 0,0, 1,1, 0, 9,10,0,0);
    add(1,1,0,0,0, 1,17, 0,1, 1, 0,10,1,1);          // illegal 17, old M wraps
    add(0,1,0,0,0, 0,0, 1,1, 0, 0,10,0,0);
    add(0,1,0,0,0, 1,0, 0,1, 0, 0,10,0,1);           // illegal 0
    add(0,1,0,0,0, 0,0, 1,1, 0, 0,10,0,0);
    add(0,1,0,0,0, 1,16, 0,1, 0, 0,16,0,0);          // full range
    for (int i = 0; i < 17; i++)
      add(1,1,0,0,0, 0,0, 0,1, (i % 16) == 15, (i + 1) % 16, 16, i == 15, 0);
    add(0,1,0,1,15, 0,0, 0,1, 0, 15,16,0,0);
    add(1,1,1,0,0, 0,0, 0,1, 1, 15,16,0,0);          // up saturate at 15
    add(0,1,0,1,4, 1,4, 0,1, 0, 3,4,0,1);            // load checked against new M
    add(1,1,1,0,0, 0,0, 1,1, 1, 3,4,0,0);
    add(1,0,0,0,0, 0,0, 0,1, 0, 2,4,0,0);
    add(1,0,0,0,0, 1,2, 0,1, 0, 0,2,0,0);            // fix-up while counting down
    add(1,0,0,0,0, 0,0, 0,1, 1, 1,2,1,0);
    add(1,1,0,0,0, 0,0, 0,0, 1, 0,10,0,0);           // reset mid-run

    foreach (vecs[i]) drive(vecs[i], i);

    // drain scoreboard with a bound
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    // --- cascade: two decimal stages
    @(negedge clk); rst_c = 1'b0;
    @(posedge clk); #1; chk_chain("chain_reset", 0);
    @(negedge clk); rst_c = 1'b1;
    for (int i = 0; i < 137; i++) begin
      @(posedge clk); #1;
      chk_chain("chain_count", (i + 1) % 100);
    end
    @(negedge clk); rst_c = 1'b0;
    @(posedge clk); #1; chk_chain("chain_midreset", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
